// File: rtl/voice_osc_p_pkg.sv
// Shared synth package: widths, stage bundles, ROM generators.
// Tables are built at elaboration from plain real arithmetic.
package voice_osc_p_pkg;

  localparam int PHASE_W = 24;
  localparam int OUT_W   = 24;
  localparam int MIDI_W  = 7;
  localparam int MAG_W   = 23;
  localparam int ADDR_W  = 8;

  localparam logic [MIDI_W-1:0] MIDI_OFF = '0;

  typedef struct packed {
    logic [ADDR_W+1:0] ph;
    logic [MIDI_W-1:0] midi;
    logic              v;
  } s1_t;

  typedef struct packed {
    logic              msb;
    logic [ADDR_W-1:0] a;
    logic [MIDI_W-1:0] midi;
    logic              v;
  } s2_t;

  typedef struct packed {
    logic              msb;
    logic [MIDI_W-1:0] midi;
    logic              v;
    logic              sen;
    logic              qen;
  } s3_t;

  function automatic real exp_r(real x);
    real s;
    real t;
    s = 1.0;
    t = 1.0;
    for (int k = 1; k < 40; k++) begin
      t = t * x / k;
      s = s + t;
    end
    return s;
  endfunction

  function automatic real sin_r(real x);
    real s;
    real t;
    s = x;
    t = x;
    for (int k = 1; k < 14; k++) begin
      t = -t * x * x / ((2 * k) * (2 * k + 1));
      s = s + t;
    end
    return s;
  endfunction

  // Per-sample phase step for 48 kHz, A4 = 440 Hz.
  function automatic logic [PHASE_W-1:0] inc_val(int m);
    real f;
    f = 440.0 * exp_r(0.6931471805599453 * (m - 69) / 12.0);
    return PHASE_W'($rtoi(f * 16777216.0 / 48000.0 + 0.5));
  endfunction

  function automatic logic [MAG_W-1:0] lut_val(int a);
    real x;
    x = 1.5707963267948966 * (a + 0.5) / 256.0;
    return MAG_W'($rtoi(8388607.0 * sin_r(x) + 0.5));
  endfunction

endpackage

// File: rtl/voice_osc_p_if.sv
// Control/data bundle between bank manager,
// oscillator core and filter/mixer stage.
interface voice_osc_p_if;
  import voice_osc_p_pkg::*;

  logic                     clk_en;
  logic                     sine_en;
  logic                     square_en;
  logic [MIDI_W-1:0]        i_midi;
  logic [MIDI_W-1:0]        o_midi;
  logic                     o_sine_valid;
  logic signed [OUT_W-1:0]  o_sine;
  logic                     o_square_valid;
  logic signed [OUT_W-1:0]  o_square;

  modport master (
    output clk_en, sine_en, square_en, i_midi,
    input  o_midi, o_sine_valid, o_sine,
    input  o_square_valid, o_square
  );

  modport slave (
    input  clk_en, sine_en, square_en, i_midi,
    output o_midi, o_sine_valid, o_sine,
    output o_square_valid, o_square
  );

endinterface

// File: rtl/voice_osc_p_rom.sv
// Quarter-wave sine magnitude ROM, 256 x 23,
// synchronous read gated by the sample strobe.
module quarter_sine_rom
  import voice_osc_p_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [MAG_W-1:0]  mag
);

  logic [MAG_W-1:0] rom [256];

  for (genvar g = 0; g < 256; g++) begin : g_lut
    localparam logic [MAG_W-1:0] V = lut_val(g);
    assign rom[g] = V;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= '0;
    end else if (en) begin
      mag <= rom[addr];
    end
  end

endmodule

// File: rtl/voice_osc_p.sv
// Time-multiplexed oscillator: per-slot phase bank,
// 3-stage pipeline to sine and square samples.
module voice_osc_p
  import voice_osc_p_pkg::*;
#(
  parameter int NBANKS = 10,
  parameter int SQ_AMP = 4194304
) (
  input  logic         clk,
  input  logic         rst,
  voice_osc_p_if.slave bus
);

  localparam int IDX_W = $clog2(NBANKS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBANKS - 1);
  localparam logic signed [OUT_W-1:0] SQ_P = OUT_W'(SQ_AMP);
  localparam logic signed [OUT_W-1:0] SQ_N = -SQ_P;

  logic [PHASE_W-1:0] inc_rom [128];

  for (genvar g = 0; g < 128; g++) begin : g_inc
    localparam logic [PHASE_W-1:0] V = inc_val(g);
    assign inc_rom[g] = V;
  end

  logic [IDX_W-1:0]   idx;
  logic [PHASE_W-1:0] phase [NBANKS];
  s1_t                s1;
  s2_t                s2;
  s3_t                s3;
  logic [MAG_W-1:0]   mag;
  logic               active;

  assign active = (bus.i_midi != MIDI_OFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
      for (int i = 0; i < NBANKS; i++) begin
        phase[i] <= '0;
      end
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (bus.clk_en) begin
      idx <= (idx == LAST) ? '0 : idx + 1'b1;
      // Idle slots park at 0 so the next note starts clean.
      phase[idx] <= active
        ? phase[idx] + inc_rom[bus.i_midi]
        : '0;
      s1 <= '{
        ph:   phase[idx][PHASE_W-1 -: ADDR_W+2],
        midi: bus.i_midi,
        v:    active
      };
      s2 <= '{
        msb:  s1.ph[ADDR_W+1],
        a:    s1.ph[ADDR_W]
              ? ~s1.ph[ADDR_W-1:0]
              : s1.ph[ADDR_W-1:0],
        midi: s1.midi,
        v:    s1.v
      };
      s3 <= '{
        msb:  s2.msb,
        midi: s2.midi,
        v:    s2.v,
        sen:  bus.sine_en,
        qen:  bus.square_en
      };
    end
  end

  quarter_sine_rom u_rom (
    .clk   (clk),
    .rst_n (rst),
    .en    (bus.clk_en),
    .addr  (s2.a),
    .mag   (mag)
  );

  logic signed [OUT_W-1:0] mag_s;
  logic                    sv;
  logic                    qv;

  assign mag_s = OUT_W'(mag);
  assign sv    = s3.v & s3.sen;
  assign qv    = s3.v & s3.qen;

  assign bus.o_midi         = s3.midi;
  assign bus.o_sine_valid   = sv;
  assign bus.o_square_valid = qv;
  assign bus.o_sine   = sv ? (s3.msb ? -mag_s : mag_s) : '0;
  assign bus.o_square = qv ? (s3.msb ? SQ_N : SQ_P) : '0;

endmodule

// File: tb/tb_voice_osc_p.sv
// Scoreboard bench for voice_osc_p: per-slot phase model,
// expected samples queued at issue, popped by a monitor.
module tb_voice_osc_p;

  localparam int NB = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  voice_osc_p_if bus();

  voice_osc_p #(.NBANKS(NB), .SQ_AMP(4194304)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int midi;
    int ph;
  } ent_t;

  ent_t q[$];
  int   mph [NB];
  int   slot;
  int   notes [NB];
  int   inc_tab [128];
  int   sin_tab [256];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   l_midi, l_sv, l_sine, l_qv, l_sq;

  task automatic check(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_all(string tag, int m, int s_v, int s, int q_v, int sq);
    check({tag, ".midi"}, longint'(bus.o_midi), m);
    check({tag, ".sine_valid"}, longint'(bus.o_sine_valid), s_v);
    check({tag, ".sine"}, longint'(bus.o_sine), s);
    check({tag, ".square_valid"}, longint'(bus.o_square_valid), q_v);
    check({tag, ".square"}, longint'(bus.o_square), sq);
  endtask

  task automatic model_reset();
    ent_t z;
    z.midi = 0;
    z.ph = 0;
    q.delete();
    for (int i = 0; i < NB; i++) mph[i] = 0;
    slot = 0;
    q.push_back(z);
    q.push_back(z);
    l_midi = 0; l_sv = 0; l_sine = 0; l_qv = 0; l_sq = 0;
  endtask

  function automatic int sine_of(int ph);
    int qd;
    int a;
    qd = (ph >> 22) & 3;
    a = (ph >> 14) & 255;
    if ((qd & 1) != 0) a = 255 - a;
    return (qd >= 2) ? -sin_tab[a] : sin_tab[a];
  endfunction

  // Issue side: the model consumes one note per enabled edge.
  initial forever begin
    ent_t e;
    @(posedge clk);
    if (rst && bus.clk_en) begin
      e.midi = int'(bus.i_midi);
      e.ph = mph[slot];
      mph[slot] = (e.midi != 0)
        ? ((mph[slot] + inc_tab[e.midi]) & 24'hFFFFFF) : 0;
      q.push_back(e);
      slot = (slot + 1) % NB;
    end
  end

  // Monitor: outputs after edge n reflect the note issued at edge n-2.
  initial forever begin
    ent_t e;
    @(posedge clk);
    #1;
    if (!rst) begin
      check_all("in_reset", 0, 0, 0, 0, 0);
    end else if (bus.clk_en) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty @%0t: got 0 entries expected >0", $time);
      end else begin
        e = q.pop_front();
        l_midi = e.midi;
        l_sv = (e.midi != 0 && bus.sine_en) ? 1 : 0;
        l_qv = (e.midi != 0 && bus.square_en) ? 1 : 0;
        l_sine = l_sv ? sine_of(e.ph) : 0;
        l_sq = l_qv ? ((e.ph >= 8388608) ? -4194304 : 4194304) : 0;
        check_all("sample", l_midi, l_sv, l_sine, l_qv, l_sq);
      end
    end else begin
      check_all("hold", l_midi, l_sv, l_sine, l_qv, l_sq);
    end
  end

  task automatic cyc(bit en, bit se, bit qe);
    @(negedge clk);
    bus.clk_en = en;
    bus.sine_en = se;
    bus.square_en = qe;
    bus.i_midi = en ? 7'(notes[slot]) : 7'($urandom);
  endtask

  initial begin
    for (int m = 0; m < 128; m++)
      inc_tab[m] = $rtoi(440.0 * $pow(2.0, (m - 69) / 12.0)
                         * 16777216.0 / 48000.0 + 0.5);
    for (int a = 0; a < 256; a++)
      sin_tab[a] = $rtoi(8388607.0 * $sin(3.14159265358979 / 2.0
                         * (a + 0.5) / 256.0) + 0.5);
    for (int i = 0; i < NB; i++) notes[i] = 0;
    model_reset();
    bus.clk_en = 1'b0;
    bus.sine_en = 1'b0;
    bus.square_en = 1'b0;
    bus.i_midi = '0;

    repeat (3) @(negedge clk);
    check_all("por", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    repeat (30) cyc(1, 1, 1);

    notes[0] = 69;
    repeat (3) cyc(1, 1, 0);
    @(posedge clk);
    #2;
    check_all("first_note", 69, 1, 25736, 0, 0);
    repeat (40) cyc(1, 1, 0);

    notes[0] = 127;
    repeat (60) cyc(1, 0, 1);

    repeat (10) begin
      cyc(1, 1, 1);
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      cyc(1, 1, 1);
    end

    for (int i = 0; i < NB; i++) notes[i] = 0;
    notes[3] = 69;
    repeat (25) cyc(1, 1, 1);
    notes[3] = 0;
    repeat (10) cyc(1, 1, 1);
    notes[3] = 69;
    repeat (25) cyc(1, 1, 1);

    repeat (1500) begin
      if ($urandom_range(0, 19) == 0) begin
        int s;
        s = $urandom_range(0, NB - 1);
        notes[s] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 127);
      end
      cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < NB; i++) notes[i] = $urandom_range(1, 127);
    repeat (25) cyc(1, 1, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.clk_en = 1'b1;
    bus.sine_en = 1'b1;
    bus.square_en = 1'b1;
    bus.i_midi = 7'(notes[0]);
    repeat (2) cyc(1, 1, 1);
    @(posedge clk);
    #2;
    check_all("post_reset", notes[0], 1, 25736, 1, 4194304);
    repeat (30) cyc(1, 1, 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/voice_osc_p.md
# voice_osc_p

Time-multiplexed oscillator core for the polyphonic synth voice path. It serves NBANKS voice slots in round-robin order, one slot per enabled cycle. For each slot it keeps a phase accumulator driven by a MIDI note number and emits a sine sample (quarter-wave ROM) and/or a square sample. It sits between the bank manager, which supplies one MIDI note per slot, and the filter/mixer stage.

## Interface
- NBANKS, 10: number of voice slots; valid range 2..16.
- PHASE_W, 24: phase accumulator width.
- OUT_W, 24: signed sample width.
- SQ_AMP, 4194304: square wave magnitude (half of full scale).
- clk  in  1  system clock.
- rst  in  1  reset; one clock domain, asynchronous, active-low.
- clk_en  in  1  sample-rate strobe; the whole block advances only when high.
- sine_en  in  1  enables the sine output path.
- square_en  in  1  enables the square output path.
- i_midi  in  7  note for the current slot; 0 means the slot is idle.
- o_midi  out  7  note aligned with the output samples.
- o_sine_valid  out  1  o_sine carries an active voice.
- o_sine  out  OUT_W signed  sine sample.
- o_square_valid  out  1  o_square carries an active voice.
- o_square  out  OUT_W signed  square sample.

## Operation
- Slot counter `idx` (0..NBANKS-1) selects the slot. It increments on every clk_en cycle and wraps from NBANKS-1 to 0.
- Stage 1, phase bank: on clk_en, register `ph1 = phase[idx]`, `midi1 = i_midi` and `v1 = (i_midi != 0)`.
  - If i_midi ≠ 0: `phase[idx] <= phase[idx] + inc(i_midi)`, modulo 2^PHASE_W.
  - If i_midi = 0: `phase[idx] <= 0`, so a new note always starts at phase 0.
- Increment ROM, 128 entries: `inc(m) = round(440·2^((m−69)/12) · 2^24 / 48000)`.
  - inc(69) = 153791, inc(57) = 76896.
  - inc(0) is unused.
- Stage 2: register quadrant `q = ph1[23:22]`, address `a = ph1[21:14]`, midi and valid.
  - If q is odd, use the mirrored address `a = ~ph1[21:14]`.
- Stage 3, outputs:
  - Sine LUT, 256 entries: `LUT[a] = round(8388607·sin(π/2·(a+0.5)/256))`. LUT[0] = 25736.
  - Sine sample: `s = LUT[a]` for q = 0 or 1, `s = −LUT[a]` for q = 2 or 3 (two's complement).
  - Square sample: `+SQ_AMP` when the phase MSB is 0, `−SQ_AMP` when it is 1. The phase MSB is carried through stage 2.
  - `o_sine = (valid && sine_en) ? s : 0`; `o_sine_valid = valid && sine_en`.
  - `o_square` and `o_square_valid` follow the same rule with square_en.
  - `o_midi` is always passed through, regardless of the enables.
- sine_en and square_en are sampled at stage 3; both may be high at once.

## Timing
- Latency: i_midi presented in clk_en cycle n appears on the outputs after the edge ending clk_en cycle n+2. Cycles with clk_en low do not count.
- When clk_en is low, every register holds: idx, accumulators, pipeline registers and outputs.
- Reset (low, asynchronous): idx = 0, all phase[] = 0, all pipeline registers = 0.
  - Outputs during reset: o_midi = 0, both valids = 0, o_sine = o_square = 0.
- Reset asserted mid-operation clears state immediately; the first slot served after release is 0.
- Phase overflow wraps silently.
- Each slot's phase updates exactly once per NBANKS clk_en cycles.

## Structure
- Shared synth package holds:
  - the widths (PHASE_W, OUT_W, MIDI_W = 7);
  - MIDI_OFF = 0;
  - the increment-ROM and sine-LUT generator functions or init files.
- One sub-module, `quarter_sine_rom`: 256×23-bit synchronous-read ROM, address in, magnitude out.
- Everything else stays inline: phase array, slot counter, pipeline, square logic.

## Test plan
- Reset, clk_en = 1, i_midi = 0 everywhere -> o_sine = o_square = 0, both valids = 0, idx walks 0..9 and wraps.
- Slot 0 = note 69, others 0, sine_en = 1:
  - 3 clk_en cycles later: o_sine_valid = 1, o_midi = 69, o_sine = 25736 (phase 0).
  - Next visit to slot 0: phase 153791.
  - Other slots: 0.
- Phase 2^23 injected via many visits (or forced): o_sine = −LUT[a].
  - Square: square_en = 1, sine_en = 0 -> o_square = −4194304, o_sine = 0, o_sine_valid = 0.
- clk_en toggling 1,0,0,1 -> outputs and idx hold through the low cycles; latency counted in enabled cycles only.
- Note 69 → 0 → 69 on slot 3 -> phase restarts at 0; sample equals the first-note sample.
- Reset asserted mid-stream with 10 active notes -> all outputs 0 immediately; after release, slot 0 output reappears with phase 0.
